// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side blocks: width helper and default sizing.
package fifo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    localparam int MIN_BUF_DEPTH = 2;
    localparam int MIN_LEVEL_W   = clog2(MIN_BUF_DEPTH + 1);

endpackage

// File: rtl/reg_fifo_buf.sv
// Small register-array FIFO used as the prefetch buffer; pointers wrap at BUF_DEPTH-1
// so any depth works, not just powers of two.
module reg_fifo_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2,
    parameter int LVL_W      = clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [LVL_W-1:0]      level_o
);

    localparam int                PTR_W    = clog2(BUF_DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(BUF_DEPTH - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  do_wr;
    logic                  do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A write into a full buffer is only legal when a read frees a slot the same cycle.
    assign do_rd = rd_en_i && (level_q != '0);
    assign do_wr = wr_en_i && ((level_q != FULL_LVL) || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_rd) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_wr && !do_rd) begin
                level_d = level_q + LVL_W'(1);
            end else if (!do_wr && do_rd) begin
                level_d = level_q - LVL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_wr && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/fifo_read_adapter.sv
// Turns a FIFO read port (ReadEn/Empty/Data, 1-cycle latency) into a valid/ready stream,
// prefetching into a small buffer so a ready sink sees one word per cycle.
module fifo_read_adapter
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                             Clk,
    input  logic                             Rst_in,
    input  logic                             Clear_in,
    output logic                             ReadEn_out,
    input  logic                             Empty_in,
    input  logic [DATA_WIDTH-1:0]            Data_in,
    output logic [DATA_WIDTH-1:0]            Data_out,
    output logic                             Valid_out,
    input  logic                             Ready_in,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   Level_out
);

    localparam int                LVL_W    = clog2(BUF_DEPTH + 1);
    localparam logic [LVL_W:0]    DEPTH_C  = (LVL_W + 1)'(BUF_DEPTH);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(BUF_DEPTH);

    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic                  buf_wr;
    logic [LVL_W-1:0]      level;
    logic [LVL_W:0]        occupancy;
    logic [DATA_WIDTH-1:0] head_data;

    // Stream handshake: a beat transfers on any cycle with Valid_out & Ready_in; once
    // Valid_out is high, Valid_out/Data_out hold until that transfer, a Clear_in or reset.
    assign Valid_out = (level != '0);
    assign pop       = Valid_out && Ready_in;
    assign Data_out  = Valid_out ? head_data : '0;

    // Slots committed after this cycle: held words plus the returning word minus the beat leaving.
    assign occupancy  = {1'b0, level} + {{LVL_W{1'b0}}, inflight_q} - {{LVL_W{1'b0}}, pop};
    assign ReadEn_out = !Rst_in && !Empty_in && !Clear_in && (occupancy < DEPTH_C);

    assign inflight_d = ReadEn_out;
    assign buf_wr     = inflight_q && !Clear_in;

    always_ff @(posedge Clk or posedge Rst_in) begin
        if (Rst_in) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    reg_fifo_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH),
        .LVL_W      (LVL_W)
    ) u_buf (
        .clk_i     (Clk),
        .rst_i     (Rst_in),
        .flush_i   (Clear_in),
        .wr_en_i   (buf_wr),
        .wr_data_i (Data_in),
        .rd_en_i   (pop),
        .rd_data_o (head_data),
        .level_o   (level)
    );

    assign Level_out = level;

    // The issue rule guarantees room for every returning word; these catch a broken rule.
    always @(posedge Clk) begin
        if (!Rst_in) begin
            assert (!(buf_wr && !pop && (level == FULL_LVL)));
            assert (level <= FULL_LVL);
            assert (!(ReadEn_out && Empty_in));
        end
    end

endmodule

// File: tb/tb_fifo_read_adapter.sv
// Bench for fifo_read_adapter: queue-based model of the prefetch buffer checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_fifo_read_adapter;

    localparam int DW    = 8;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          Clk;
    logic          Rst_in;
    logic          Clear_in;
    logic          ReadEn_out;
    logic          Empty_in;
    logic [DW-1:0] Data_in;
    logic [DW-1:0] Data_out;
    logic          Valid_out;
    logic          Ready_in;
    logic [LW-1:0] Level_out;

    fifo_read_adapter #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (DEPTH)
    ) dut (
        .Clk        (Clk),
        .Rst_in     (Rst_in),
        .Clear_in   (Clear_in),
        .ReadEn_out (ReadEn_out),
        .Empty_in   (Empty_in),
        .Data_in    (Data_in),
        .Data_out   (Data_out),
        .Valid_out  (Valid_out),
        .Ready_in   (Ready_in),
        .Level_out  (Level_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- environment and model state ----------------
    logic [DW-1:0] src_q[$];    // words held by the upstream FIFO
    logic [DW-1:0] exp_q[$];    // words the adapter buffer must hold, oldest first
    logic [DW-1:0] got_q[$];    // beats taken by the sink
    logic          m_inf;
    logic [DW-1:0] m_inf_word;
    logic          rd_pending;
    logic [DW-1:0] rd_word;
    logic          stall_prev;
    logic [DW-1:0] prev_data;
    int            n_reads;
    int            n_pass;
    int            n_total;

    logic          last_ren;
    logic          last_valid;
    logic [DW-1:0] last_data;
    logic [LW-1:0] last_level;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_inf      = 1'b0;
        rd_pending = 1'b0;
        stall_prev = 1'b0;
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Called at posedge+1; drives this cycle's inputs, checks at negedge, advances the model.
    task automatic cycle(input logic rdy, input logic clr);
        int            sz;
        int            occ;
        logic          exp_pop;
        logic          exp_ren;
        logic [DW-1:0] exp_data;
        Ready_in = rdy;
        Clear_in = clr;
        Empty_in = (src_q.size() == 0);
        @(negedge Clk);
        sz       = exp_q.size();
        exp_pop  = (sz != 0) && Ready_in;
        occ      = sz + (m_inf ? 1 : 0) - (exp_pop ? 1 : 0);
        exp_ren  = !Rst_in && !Empty_in && !Clear_in && (occ < DEPTH);
        exp_data = (sz != 0) ? exp_q[0] : '0;
        chk("read_en", 32'(ReadEn_out), 32'(exp_ren));
        chk("valid",   32'(Valid_out),  32'(sz != 0));
        chk("level",   32'(Level_out),  32'(sz));
        chk("data",    32'(Data_out),   32'(exp_data));
        if (stall_prev) begin
            chk("stall_valid", 32'(Valid_out), 32'(1));
            chk("stall_data",  32'(Data_out),  32'(prev_data));
        end
        stall_prev = Valid_out && !Ready_in && !Clear_in && !Rst_in;
        prev_data  = Data_out;
        last_ren   = ReadEn_out;
        last_valid = Valid_out;
        last_data  = Data_out;
        last_level = Level_out;
        if (Valid_out && Ready_in && !Rst_in) begin
            got_q.push_back(Data_out);
        end
        if (Rst_in) begin
            model_reset();
        end else if (Clear_in) begin
            exp_q.delete();
            m_inf = 1'b0;
        end else begin
            if (exp_pop) begin
                void'(exp_q.pop_front());
            end
            if (m_inf) begin
                exp_q.push_back(m_inf_word);
            end
            chk("no_overflow", 32'(exp_q.size() <= DEPTH), 32'(1));
            m_inf = ReadEn_out;
        end
        if (ReadEn_out && !Rst_in) begin
            rd_word    = (src_q.size() != 0) ? src_q.pop_front() : DW'($urandom);
            m_inf_word = rd_word;
            rd_pending = 1'b1;
            n_reads++;
        end
        @(posedge Clk);
        #1;
        Data_in    = rd_pending ? rd_word : DW'($urandom);
        rd_pending = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0);
        end
    endtask

    // ---------------- stimulus + scoreboard report ----------------
    initial begin
        int            bad;
        int            fill_pct;
        int            r0;
        logic [31:0]   ren_mask;
        logic [31:0]   val_mask;

        n_pass   = 0;
        n_total  = 0;
        n_reads  = 0;
        Rst_in   = 1'b1;
        Clear_in = 1'b0;
        Ready_in = 1'b1;
        Empty_in = 1'b0;
        Data_in  = '0;
        model_reset();
        src_q = '{8'h10, 8'h20, 8'h30};
        @(posedge Clk);
        #1;

        // Reset held with a non-empty FIFO and a ready sink: everything stays cleared.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0);
        end
        chk("rst_ren",   32'(last_ren),   32'(0));
        chk("rst_valid", 32'(last_valid), 32'(0));
        chk("rst_level", 32'(last_level), 32'(0));
        chk("rst_data",  32'(last_data),  32'(0));

        // Release, let two words prefetch under backpressure, then reset between edges.
        Rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0);
        end
        chk("pre_arst_level", 32'(last_level), 32'(2));
        chk("pre_arst_data",  32'(last_data),  32'(8'h10));
        #2;
        Rst_in = 1'b1;
        #1;
        chk("arst_ren",   32'(ReadEn_out), 32'(0));
        chk("arst_valid", 32'(Valid_out),  32'(0));
        chk("arst_level", 32'(Level_out),  32'(0));
        chk("arst_data",  32'(Data_out),   32'(0));
        model_reset();
        src_q.delete();
        @(posedge Clk);
        #1;
        cycle(1'b1, 1'b0);
        Rst_in = 1'b0;
        idle(2);

        // Single word: one read, visible two cycles later for exactly one beat.
        src_q.push_back(8'hA5);
        cycle(1'b1, 1'b0);
        chk("single_ren_c0", 32'(last_ren), 32'(1));
        cycle(1'b1, 1'b0);
        chk("single_ren_c1",   32'(last_ren),   32'(0));
        chk("single_valid_c1", 32'(last_valid), 32'(0));
        cycle(1'b1, 1'b0);
        chk("single_valid_c2", 32'(last_valid), 32'(1));
        chk("single_data_c2",  32'(last_data),  32'(8'hA5));
        cycle(1'b1, 1'b0);
        chk("single_valid_c3", 32'(last_valid), 32'(0));
        idle(2);

        // Streaming: 16 back-to-back reads and 16 bubble-free beats two cycles behind.
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(DW'(i));
        end
        ren_mask = '0;
        val_mask = '0;
        bad      = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            ren_mask[i] = last_ren;
            val_mask[i] = last_valid;
            if (last_valid && (32'(last_data) != 32'(i - 2))) begin
                bad++;
            end
        end
        chk("stream_ren_mask",   ren_mask,  32'h0000_FFFF);
        chk("stream_valid_mask", val_mask,  32'h0003_FFFC);
        chk("stream_data_errs",  32'(bad),  32'(0));

        // Backpressure after beat 3: two words parked, head holds 4, then nothing lost.
        got_q.delete();
        r0 = n_reads;
        for (int i = 0; i < 16; i++) begin
            src_q.push_back(DW'(i));
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0);
        end
        chk("bp_level",       32'(last_level),                     32'(2));
        chk("bp_data",        32'(last_data),                      32'(4));
        chk("bp_outstanding", 32'(n_reads - r0 - got_q.size()),    32'(2));
        idle(25);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) begin
            if (32'(got_q[i]) != 32'(i)) begin
                bad++;
            end
        end
        chk("bp_beats",     32'(got_q.size()), 32'(16));
        chk("bp_data_errs", 32'(bad),          32'(0));

        // Clear with one word held and one in flight: both disappear.
        src_q.push_back(8'h11);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("clr_pre_level", 32'(last_level), 32'(1));
        src_q.push_back(8'h22);
        cycle(1'b0, 1'b0);
        chk("clr_pre_ren", 32'(last_ren), 32'(1));
        cycle(1'b0, 1'b1);
        chk("clr_ren_low", 32'(last_ren), 32'(0));
        got_q.delete();
        cycle(1'b1, 1'b0);
        chk("clr_valid", 32'(last_valid), 32'(0));
        chk("clr_level", 32'(last_level), 32'(0));
        idle(5);
        chk("clr_no_beats", 32'(got_q.size()), 32'(0));

        // Random traffic: varying fill rate, 50% ready, rare clears.
        fill_pct = 50;
        for (int c = 0; c < 2000; c++) begin
            if ((c % 100) == 0) begin
                fill_pct = $urandom_range(90, 10);
            end
            if (($urandom_range(99, 0) < fill_pct) && (src_q.size() < 32)) begin
                src_q.push_back(DW'($urandom));
            end
            cycle(1'($urandom_range(1, 0)), ($urandom_range(199, 0) == 0));
        end
        idle(40);
        chk("drain_level", 32'(last_level),   32'(0));
        chk("drain_valid", 32'(last_valid),   32'(0));
        chk("drain_src",   32'(src_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
